// File: rtl/basic_loops_host.sv
// Host-side controller for the basic_loops HLS core.
// Owns the 16x8 input array and drives the ap_ctrl_hs handshake.
//
// Ports:
//   ap_clk, ap_rst               clock, sync active-high reset
//   wr_en, wr_addr, wr_data      host array write port
//   run                          request one core invocation
//   busy, res_valid, res_data,
//   res_timeout                  invocation status and result
//   ap_start/done/idle/ready     core control handshake
//   A_address0, A_ce0, A_q0      core array read port, 1-cycle latency
//   ap_return                    core result
module basic_loops_host #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 4,
  parameter int DEPTH       = 16,
  parameter int RET_W       = 13,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              run,
  output logic              busy,
  output logic              res_valid,
  output logic [RET_W-1:0]  res_data,
  output logic              res_timeout,
  output logic              ap_start,
  input  logic              ap_done,
  input  logic              ap_idle,
  input  logic              ap_ready,
  input  logic [ADDR_W-1:0] A_address0,
  input  logic              A_ce0,
  output logic [DATA_W-1:0] A_q0,
  input  logic [RET_W-1:0]  ap_return
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_DONE
  } state_t;

  state_t            state;
  state_t            state_d;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_d;
  logic [RET_W-1:0]  res_q;
  logic [RET_W-1:0]  res_d;
  logic              tmo_q;
  logic              tmo_d;
  logic              wr_ok;
  logic              expired;
  logic [DATA_W-1:0] mem [DEPTH];

  // ap_idle is status only; it never steers sequencing.
  logic unused_idle;
  assign unused_idle = ap_idle;

  assign res_data    = res_q;
  assign res_timeout = tmo_q;

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      res_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      res_q <= res_d;
      tmo_q <= tmo_d;
    end
  end

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    res_d     = res_q;
    tmo_d     = tmo_q;
    ap_start  = 1'b0;
    busy      = 1'b0;
    res_valid = 1'b0;
    wr_ok     = 1'b0;
    expired   = (cnt == CNT_W'(TIMEOUT_CYC));
    unique case (state)
      S_IDLE: begin
        wr_ok = 1'b1;
        if (run) begin
          state_d = S_START;
          cnt_d   = '0;
          tmo_d   = 1'b0;
        end
      end
      S_START: begin
        ap_start = 1'b1;
        busy     = 1'b1;
        cnt_d    = cnt + 1'b1;
        // done wins over ready and over an expiring counter
        if (ap_done) begin
          res_d   = ap_return;
          state_d = S_DONE;
        end else if (expired) begin
          res_d   = '0;
          tmo_d   = 1'b1;
          state_d = S_DONE;
        end else if (ap_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        busy  = 1'b1;
        cnt_d = cnt + 1'b1;
        if (ap_done) begin
          res_d   = ap_return;
          state_d = S_DONE;
        end else if (expired) begin
          res_d   = '0;
          tmo_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        wr_ok     = 1'b1;
        res_valid = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Array is never cleared by reset; frozen while the core runs.
  always_ff @(posedge ap_clk) begin
    if (wr_en && wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      A_q0 <= '0;
    end else if (A_ce0) begin
      A_q0 <= mem[A_address0];
    end
  end

endmodule

// File: tb/tb_basic_loops_host.sv
// Directed bench for basic_loops_host.
// Drives the core side by hand; a second instance covers timeout.
module tb_basic_loops_host;

  logic        clk = 1'b0;
  logic        ap_rst;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        run;
  logic        busy;
  logic        res_valid;
  logic [12:0] res_data;
  logic        res_timeout;
  logic        ap_start;
  logic        ap_done;
  logic        ap_idle;
  logic        ap_ready;
  logic [3:0]  a_addr;
  logic        a_ce;
  logic [7:0]  a_q;
  logic [12:0] ap_return;

  logic        t_run;
  logic        t_busy;
  logic        t_valid;
  logic [12:0] t_data;
  logic        t_tmo;
  logic        t_start;
  logic [7:0]  t_q;

  int n_cmp = 0;
  int n_err = 0;
  int sum;
  int n;

  always #5 clk = ~clk;

  basic_loops_host dut (
    .ap_clk      (clk),
    .ap_rst      (ap_rst),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .run         (run),
    .busy        (busy),
    .res_valid   (res_valid),
    .res_data    (res_data),
    .res_timeout (res_timeout),
    .ap_start    (ap_start),
    .ap_done     (ap_done),
    .ap_idle     (ap_idle),
    .ap_ready    (ap_ready),
    .A_address0  (a_addr),
    .A_ce0       (a_ce),
    .A_q0        (a_q),
    .ap_return   (ap_return)
  );

  basic_loops_host #(.TIMEOUT_CYC(20)) dut_t (
    .ap_clk      (clk),
    .ap_rst      (ap_rst),
    .wr_en       (1'b0),
    .wr_addr     (4'd0),
    .wr_data     (8'd0),
    .run         (t_run),
    .busy        (t_busy),
    .res_valid   (t_valid),
    .res_data    (t_data),
    .res_timeout (t_tmo),
    .ap_start    (t_start),
    .ap_done     (1'b0),
    .ap_idle     (1'b1),
    .ap_ready    (1'b0),
    .A_address0  (4'd0),
    .A_ce0       (1'b0),
    .A_q0        (t_q),
    .ap_return   (13'h1FFF)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic go_wait();
    run = 1'b1;
    tick();
    run = 1'b0;
    ap_ready = 1'b1;
    tick();
    ap_ready = 1'b0;
  endtask

  initial begin
    ap_rst    = 1'b1;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    run       = 1'b0;
    ap_done   = 1'b0;
    ap_idle   = 1'b1;
    ap_ready  = 1'b0;
    a_addr    = '0;
    a_ce      = 1'b0;
    ap_return = '0;
    t_run     = 1'b0;
    tick();
    tick();
    chk("rst_start", ap_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_tmo", res_timeout, 0);
    chk("rst_data", res_data, 0);
    chk("rst_q", a_q, 0);
    ap_rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      wr_en   = 1'b1;
      wr_addr = 4'(i);
      wr_data = 8'(i + 1);
      tick();
    end
    wr_en = 1'b0;

    // 1: sequential sum
    run = 1'b1;
    tick();
    run = 1'b0;
    chk("t1_start", ap_start, 1);
    chk("t1_busy", busy, 1);
    ap_ready = 1'b1;
    tick();
    ap_ready = 1'b0;
    chk("t1_start_drop", ap_start, 0);
    sum = 0;
    for (int i = 0; i < 16; i++) begin
      a_addr = 4'(i);
      a_ce   = 1'b1;
      tick();
      chk($sformatf("t1_q%0d", i), a_q, i + 1);
      sum += int'(a_q);
    end
    a_ce      = 1'b0;
    ap_done   = 1'b1;
    ap_return = 13'(sum);
    tick();
    ap_done = 1'b0;
    chk("t1_valid", res_valid, 1);
    chk("t1_data", res_data, 136);
    chk("t1_tmo", res_timeout, 0);
    chk("t1_busy_done", busy, 0);
    tick();
    chk("t1_pulse", res_valid, 0);
    chk("t1_hold", res_data, 136);

    // 2: ready and done together; run in DONE ignored
    run = 1'b1;
    tick();
    run = 1'b0;
    chk("t2_start", ap_start, 1);
    ap_ready  = 1'b1;
    ap_done   = 1'b1;
    ap_return = 13'h1ABC;
    tick();
    ap_ready = 1'b0;
    ap_done  = 1'b0;
    chk("t2_start_drop", ap_start, 0);
    chk("t2_valid", res_valid, 1);
    chk("t2_data", res_data, 13'h1ABC);
    run = 1'b1;
    tick();
    run = 1'b0;
    chk("t2_run_in_done", busy, 0);
    chk("t2_pulse", res_valid, 0);
    tick();
    chk("t2_no_start", ap_start, 0);

    // 3: timeout on the TIMEOUT_CYC=20 instance
    t_run = 1'b1;
    tick();
    t_run = 1'b0;
    chk("t3_start", t_start, 1);
    n = 0;
    while (!t_valid && n < 40) begin
      tick();
      n++;
    end
    chk("t3_cycles", n, 21);
    chk("t3_tmo", t_tmo, 1);
    chk("t3_data", t_data, 0);
    chk("t3_start_off", t_start, 0);
    tick();
    chk("t3_pulse", t_valid, 0);
    chk("t3_start_after", t_start, 0);
    chk("t3_tmo_hold", t_tmo, 1);

    // 4: write and run during WAIT are dropped
    go_wait();
    wr_en   = 1'b1;
    wr_addr = 4'd3;
    wr_data = 8'hFF;
    run     = 1'b1;
    tick();
    wr_en = 1'b0;
    run   = 1'b0;
    chk("t4_busy", busy, 1);
    a_addr = 4'd3;
    a_ce   = 1'b1;
    tick();
    a_ce = 1'b0;
    chk("t4_a3", a_q, 8'h04);
    ap_done   = 1'b1;
    ap_return = 13'd5;
    tick();
    ap_done = 1'b0;
    chk("t4_valid", res_valid, 1);
    tick();
    chk("t4_no_rerun", busy, 0);
    tick();
    chk("t4_no_start", ap_start, 0);
    a_ce = 1'b1;
    tick();
    a_ce = 1'b0;
    chk("t4_a3_idle", a_q, 8'h04);

    // 5: reset during WAIT
    go_wait();
    chk("t5_busy", busy, 1);
    ap_rst = 1'b1;
    tick();
    chk("t5_start", ap_start, 0);
    chk("t5_busy_rst", busy, 0);
    chk("t5_valid", res_valid, 0);
    ap_rst = 1'b0;
    tick();
    chk("t5_valid2", res_valid, 0);
    a_addr = 4'd5;
    a_ce   = 1'b1;
    tick();
    a_ce = 1'b0;
    chk("t5_a5", a_q, 8'h06);

    // 6: back-to-back invocations, A_q0 holds
    run = 1'b1;
    tick();
    run = 1'b0;
    ap_ready  = 1'b1;
    ap_done   = 1'b1;
    ap_return = 13'h0123;
    a_addr    = 4'd0;
    tick();
    ap_ready = 1'b0;
    ap_done  = 1'b0;
    chk("t6_valid1", res_valid, 1);
    chk("t6_data1", res_data, 13'h0123);
    chk("t6_qhold1", a_q, 8'h06);
    tick();
    run = 1'b1;
    tick();
    run = 1'b0;
    chk("t6_start2", ap_start, 1);
    ap_ready = 1'b1;
    tick();
    ap_ready = 1'b0;
    a_addr = 4'd9;
    a_ce   = 1'b1;
    tick();
    a_ce   = 1'b0;
    a_addr = 4'd0;
    chk("t6_a9", a_q, 8'd10);
    tick();
    tick();
    chk("t6_qhold2", a_q, 8'd10);
    ap_done   = 1'b1;
    ap_return = 13'h0456;
    tick();
    ap_done = 1'b0;
    chk("t6_valid2", res_valid, 1);
    chk("t6_data2", res_data, 13'h0456);
    tick();
    chk("t6_pulse", res_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/basic_loops_host.md
Name: basic_loops_host

Overview:
- Host-side counterpart of the HLS `basic_loops` core. It is the initiator of the ap_ctrl_hs handshake and the responder on the `A` memory read port.
- Holds the 16x8 input array, which is loaded through a simple write port, and serves the core's `A_address0`/`A_ce0` reads with one-cycle latency.
- Starts the core, captures `ap_return` on `ap_done`, and reports the result with a valid pulse.
- Sits between the system/SC-TB side and `basic_loops`, and replaces the testbench-driven memory and control.

Parameters:
- DATA_W, 8, array element width (`A_q0`)
- ADDR_W, 4, array address width (`A_address0`)
- DEPTH, 16, array entries (= 2**ADDR_W)
- RET_W, 13, `ap_return` width
- TIMEOUT_CYC, 1023, max cycles from start to `ap_done` before abort

Ports:
- ap_clk  in  1  clock, all logic on rising edge
- ap_rst  in  1  synchronous active-high reset
- wr_en  in  1  array write strobe (host side)
- wr_addr  in  ADDR_W  array write address
- wr_data  in  DATA_W  array write data
- run  in  1  request one core invocation
- busy  out  1  invocation in progress
- res_valid  out  1  one-cycle result strobe
- res_data  out  RET_W  captured `ap_return`
- res_timeout  out  1  last invocation aborted by timeout
- ap_start  out  1  to core
- ap_done  in  1  from core
- ap_idle  in  1  from core (status only, not used for sequencing)
- ap_ready  in  1  from core
- A_address0  in  ADDR_W  core read address
- A_ce0  in  1  core read enable
- A_q0  out  DATA_W  read data to core
- ap_return  in  RET_W  core result

Behaviour:
- Reset: one clock; reset is synchronous and active-high. Values after reset:
  - `ap_start`, `busy`, `res_valid`, `res_timeout` = 0
  - `res_data` = 0, `A_q0` = 0
  - FSM = IDLE, timeout counter = 0
  - Array contents are not cleared.
- Array write:
  - `mem[wr_addr] <= wr_data` when `wr_en` is high and the FSM is IDLE or DONE.
  - Ignored in START/WAIT, so the array is frozen while the core runs.
- Array read:
  - `A_q0 <= mem[A_address0]` on the edge where `A_ce0` = 1. Data is visible the cycle after the request (1-cycle latency).
  - `A_q0` holds its last value when `A_ce0` = 0.
  - A write and a read to the same address in the same cycle cannot occur, because writes are blocked while busy.
- FSM states: IDLE, START, WAIT, DONE.
  - IDLE:
    - `run` = 1 -> START; clear the counter and `res_timeout`.
    - A write in the same cycle as `run` still commits.
  - START:
    - `ap_start` = 1, `busy` = 1. `ap_start` is held high until `ap_ready` is sampled 1 (ap_ctrl_hs rule).
    - On `ap_ready` = 1: `ap_start` = 0 from the next cycle.
    - If `ap_done` = 1 in the same cycle -> capture and go to DONE; otherwise -> WAIT.
    - `ap_done` without `ap_ready` is also treated as completion -> DONE.
  - WAIT:
    - `ap_start` = 0, `busy` = 1.
    - `ap_done` = 1 -> `res_data <= ap_return` -> DONE.
  - DONE:
    - `res_valid` = 1 for exactly one cycle, `busy` = 0 -> IDLE.
    - A `run` seen in DONE is ignored; it must be asserted again in IDLE.
- Timeout:
  - The counter increments every cycle in START/WAIT.
  - When it reaches TIMEOUT_CYC with no `ap_done`: `ap_start` <= 0, `res_timeout` <= 1, `res_data` <= 0, -> DONE (`res_valid` pulses).
  - After a timeout the core state is undefined, and the system must pulse `ap_rst`.
- Other rules:
  - `run` while busy is ignored and not queued.
  - `res_data` and `res_timeout` hold until the next DONE.
  - `ap_rst` mid-invocation: next edge returns to IDLE, `ap_start` = 0, `busy` = 0, no `res_valid`.
  - Minimum latency: `run` -> `ap_start` high 1 cycle; `ap_done` -> `res_valid` 1 cycle.

Test Plan:
1. Load A[i] = i+1 for i = 0..15, pulse `run`; core model reads sequentially and returns the sum. Required: `ap_start` high the cycle after `run`; each `A_q0` = `A_address0`+1 one cycle after `A_ce0`; `res_data` = 13'd136 with a single `res_valid` pulse; `res_timeout` = 0.
2. Core model asserts `ap_ready` and `ap_done` in the same cycle with `ap_return` = 13'h1ABC. Required: `ap_start` drops next cycle, `res_valid` next cycle, `res_data` = 13'h1ABC.
3. Core model never asserts `ap_done`, with TIMEOUT_CYC = 20. Required: `res_valid` + `res_timeout` = 1, `res_data` = 0, exactly 21 cycles after START entry; `ap_start` = 0 afterwards.
4. During WAIT, `wr_en` to addr 3 with 8'hFF, and a second `run` pulse. Required: a later read of A[3] returns the old value 8'h04; only one invocation occurs.
5. Assert `ap_rst` while in WAIT. Required: next cycle `ap_start` = 0, `busy` = 0, no `res_valid`; array contents preserved (A[5] still 8'h06).
6. Two back-to-back invocations with `run` asserted in the first IDLE cycle after DONE. Required: two `res_valid` pulses with respective results; `A_q0` holds its value between reads when `A_ce0` = 0.
